// File: rtl/io_port_pkg.sv
// Shared types and constants for the IO port fabric and its interrupt controller.
package io_port_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [1:0] IRQ_REG_PENDING = 2'd0;
  localparam logic [1:0] IRQ_REG_ENABLE  = 2'd1;
  localparam logic [1:0] IRQ_REG_STATUS  = 2'd2;
  localparam logic [1:0] IRQ_REG_RSVD    = 2'd3;

  localparam int unsigned IO_BITS = 16;
  localparam logic [IO_BITS-1:0] ERR_DATA = {IO_BITS{1'b1}};

  // Width needed to index n slots; never narrower than one bit.
  function automatic int unsigned slot_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_port_fabric_if.sv
// CPU-side and peripheral-side bus of the IO port fabric.
interface io_port_fabric_if #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 16,
  parameter int NUM_SLOTS    = 8,
  parameter int SLOT_SHIFT   = 12
);
  logic [ADDRESS_BITS-1:0]   ADDRESS;
  logic [BITS-1:0]           DATA_IN;
  logic [BITS-1:0]           DATA_OUT;
  logic                      memWR;
  logic                      memRD;
  logic                      ready;
  logic [SLOT_SHIFT-1:0]     periph_addr;
  logic [BITS-1:0]           periph_wdata;
  logic [NUM_SLOTS-1:0]      periph_wr;
  logic [NUM_SLOTS-1:0]      periph_rd;
  logic [NUM_SLOTS*BITS-1:0] periph_rdata;
  logic [NUM_SLOTS-1:0]      periph_ack;
  logic [NUM_SLOTS-1:0]      periph_irq;
  logic                      irq;

  modport master (
    output ADDRESS, DATA_IN, memWR, memRD, periph_rdata, periph_ack, periph_irq,
    input  DATA_OUT, ready, periph_addr, periph_wdata, periph_wr, periph_rd, irq
  );

  modport slave (
    input  ADDRESS, DATA_IN, memWR, memRD, periph_rdata, periph_ack, periph_irq,
    output DATA_OUT, ready, periph_addr, periph_wdata, periph_wr, periph_rd, irq
  );
endinterface

// File: rtl/io_irq_ctrl.sv
// Interrupt controller living in the fabric's IRQ slot: edge-detected pending
// bits, enable mask, bus-error status and a registered irq output.
module io_irq_ctrl
  import io_port_pkg::*;
#(
  parameter int BITS      = 16,
  parameter int NUM_SLOTS = 8,
  parameter int IRQ_SLOT  = 7
) (
  input  logic                 CLK,
  input  logic                 RSTb,
  input  logic                 we,
  input  logic [1:0]           reg_addr,
  input  logic [NUM_SLOTS-1:0] wdata,
  input  logic                 err_set,
  input  logic [3:0]           err_slot,
  input  logic [NUM_SLOTS-1:0] irq_src,
  output logic [BITS-1:0]      rdata,
  output logic                 irq
);

  logic [NUM_SLOTS-1:0] pending_q, pending_d;
  logic [NUM_SLOTS-1:0] enable_q, enable_d;
  logic [NUM_SLOTS-1:0] irq_prev_q, irq_prev_d;
  logic                 err_q, err_d;
  logic [3:0]           err_slot_q, err_slot_d;
  logic                 irq_q, irq_d;

  logic [NUM_SLOTS-1:0] src_mask;
  logic [NUM_SLOTS-1:0] rise;

  // The IRQ slot's own line is not a source; it is this block.
  assign src_mask = ~(NUM_SLOTS'(1) << IRQ_SLOT);
  assign rise     = irq_src & ~irq_prev_q & src_mask;

  always_comb begin
    pending_d  = pending_q;
    enable_d   = enable_q;
    err_d      = err_q;
    err_slot_d = err_slot_q;
    irq_prev_d = irq_src;
    irq_d      = |(pending_q & enable_q);

    if (we && reg_addr == IRQ_REG_PENDING) pending_d = pending_q & ~wdata;
    // A fresh edge wins over a write-1-to-clear landing in the same cycle.
    pending_d = pending_d | rise;

    if (we && reg_addr == IRQ_REG_ENABLE) enable_d = wdata;
    if (we && reg_addr == IRQ_REG_STATUS && wdata[0]) err_d = 1'b0;
    if (err_set) begin
      err_d      = 1'b1;
      err_slot_d = err_slot;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_addr)
      IRQ_REG_PENDING: rdata = BITS'(pending_q);
      IRQ_REG_ENABLE:  rdata = BITS'(enable_q);
      IRQ_REG_STATUS:  rdata = BITS'({err_slot_q, 3'b000, err_q});
      default:         rdata = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      pending_q  <= '0;
      enable_q   <= '0;
      irq_prev_q <= '0;
      err_q      <= 1'b0;
      err_slot_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      irq_prev_q <= irq_prev_d;
      err_q      <= err_d;
      err_slot_q <= err_slot_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: rtl/io_port_fabric.sv
// IO port controller: slot decode, ack/timeout handshake FSM and read mux
// between the CPU memory port and NUM_SLOTS peripherals.
//   state  | meaning
//   IDLE   | wait for memWR/memRD, latch request
//   ACCESS | one-cycle strobe to selected slot; internal/unmapped slots finish here
//   WAIT   | strobe low, count cycles until ack or timeout
//   DONE   | one-cycle ready pulse, DATA_OUT valid
module io_port_fabric
  import io_port_pkg::*;
#(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 16,
  parameter int NUM_SLOTS    = 8,
  parameter int SLOT_SHIFT   = 12,
  parameter int TIMEOUT      = 15,
  parameter int IRQ_SLOT     = 7
) (
  input  logic            CLK,
  input  logic            RSTb,
  io_port_fabric_if.slave bus
);

  localparam int SFW = ADDRESS_BITS - SLOT_SHIFT;
  localparam int IW  = slot_idx_w(NUM_SLOTS);
  localparam int CW  = 8;

  state_e                state_q, state_d;
  logic [SFW-1:0]        slot_q, slot_d;
  logic                  mapped_q, mapped_d;
  logic                  wr_q, wr_d;
  logic [SLOT_SHIFT-1:0] addr_q, addr_d;
  logic [BITS-1:0]       wdata_q, wdata_d;
  logic [BITS-1:0]       data_out_q, data_out_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [IW-1:0]        slot_idx;
  logic [NUM_SLOTS-1:0] slot_oh;
  logic                 is_irq;
  logic                 is_ext;
  logic                 sel_ack;
  logic [BITS-1:0]      sel_rdata;
  logic                 err_set;
  logic                 irq_we;
  logic [BITS-1:0]      irq_rdata;

  assign slot_idx  = slot_q[IW-1:0];
  assign slot_oh   = NUM_SLOTS'(1) << slot_idx;
  assign is_irq    = mapped_q && (slot_idx == IW'(IRQ_SLOT));
  assign is_ext    = mapped_q && !is_irq;
  assign sel_ack   = bus.periph_ack[slot_idx];
  assign sel_rdata = bus.periph_rdata[int'(slot_idx)*BITS +: BITS];

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    mapped_d   = mapped_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    cnt_d      = cnt_q;
    err_set    = 1'b0;
    irq_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.memWR || bus.memRD) begin
          slot_d   = bus.ADDRESS[ADDRESS_BITS-1:SLOT_SHIFT];
          mapped_d = 32'(bus.ADDRESS[ADDRESS_BITS-1:SLOT_SHIFT]) < 32'(NUM_SLOTS);
          wr_d     = bus.memWR;
          addr_d   = bus.ADDRESS[SLOT_SHIFT-1:0];
          wdata_d  = bus.DATA_IN;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = '0;
        if (!is_ext) begin
          // Internal register file and unmapped space both answer immediately.
          state_d = DONE;
          irq_we  = is_irq && wr_q;
          if (!wr_q) data_out_d = is_irq ? irq_rdata : '0;
        end else if (sel_ack) begin
          state_d = DONE;
          if (!wr_q) data_out_d = sel_rdata;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (sel_ack) begin
          state_d = DONE;
          if (!wr_q) data_out_d = sel_rdata;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // TIMEOUT WAIT cycles have elapsed without an ack.
          state_d    = DONE;
          data_out_d = BITS'(ERR_DATA);
          err_set    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      mapped_q   <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      mapped_q   <= mapped_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      cnt_q      <= cnt_d;
    end
  end

  io_irq_ctrl #(
    .BITS      (BITS),
    .NUM_SLOTS (NUM_SLOTS),
    .IRQ_SLOT  (IRQ_SLOT)
  ) u_irq_ctrl (
    .CLK      (CLK),
    .RSTb     (RSTb),
    .we       (irq_we),
    .reg_addr (addr_q[1:0]),
    .wdata    (wdata_q[NUM_SLOTS-1:0]),
    .err_set  (err_set),
    .err_slot (4'(slot_q)),
    .irq_src  (bus.periph_irq),
    .rdata    (irq_rdata),
    .irq      (bus.irq)
  );

  assign bus.DATA_OUT     = data_out_q;
  assign bus.ready        = (state_q == DONE);
  assign bus.periph_addr  = addr_q;
  assign bus.periph_wdata = wdata_q;
  assign bus.periph_wr    = (state_q == ACCESS && is_ext && wr_q)  ? slot_oh : '0;
  assign bus.periph_rd    = (state_q == ACCESS && is_ext && !wr_q) ? slot_oh : '0;

endmodule
